usb_rx_bit_timer: RTL and testbench

//  Bit-timing and bit-unstuffing stage of the USB receiver, directly upstream of the RX shift register and byte counter.

---
 rtl/usb_rx_bit_timer.sv | 124 ++++++++++++
 tb/tb_usb_rx_bit_timer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/usb_rx_bit_timer.sv
// USB RX bit timer: tracks bit phase, resyncs on line edges, samples once per bit and unstuffs.
// Optional macro RX_BIT_UNSTUFF_EN enables stuffed-bit removal and bit-stuff error detection.
module usb_rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT  = 8,
  parameter int unsigned SAMPLE_PHASE  = 3,
  parameter int unsigned BITS_PER_BYTE = 8,
  parameter int unsigned STUFF_LIMIT   = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable_timer,
  input  logic d_edge,
  input  logic d_orig,
  output logic shift_enable,
  output logic byte_received,
  output logic stuff_skip,
  output logic bit_stuff_err
);

  localparam int unsigned PhaseW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW   = $clog2(BITS_PER_BYTE);

  localparam logic [PhaseW-1:0] PhaseMax = PhaseW'(CLKS_PER_BIT - 1);
  localparam logic [PhaseW-1:0] SampleAt = PhaseW'(SAMPLE_PHASE);
  localparam logic [BitW-1:0]   BitMax   = BitW'(BITS_PER_BYTE - 1);

  logic [PhaseW-1:0] phase_q, phase_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              shift_q, shift_d;
  logic              byte_q, byte_d;
  logic              skip_q, skip_d;
  logic              err_q, err_d;

`ifdef RX_BIT_UNSTUFF_EN
  localparam int unsigned OnesW = $clog2(STUFF_LIMIT + 1);
  localparam logic [OnesW-1:0] OnesMax = OnesW'(STUFF_LIMIT);

  logic [OnesW-1:0] ones_cnt_q, ones_cnt_d;
`else
  localparam int unsigned unused_stuff_limit = STUFF_LIMIT;
  logic unused_d_orig;
  assign unused_d_orig = d_orig;
`endif

  always_comb begin
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = 1'b0;
    byte_d    = 1'b0;
    skip_d    = 1'b0;
    err_d     = 1'b0;
`ifdef RX_BIT_UNSTUFF_EN
    ones_cnt_d = ones_cnt_q;
`endif
    if (!enable_timer) begin
      phase_d   = '0;
      bit_cnt_d = '0;
`ifdef RX_BIT_UNSTUFF_EN
      ones_cnt_d = '0;
`endif
    end else begin
      // An edge cycle counts as phase 0, so the following cycle is phase 1.
      if (d_edge) begin
        phase_d = PhaseW'(1);
      end else if (phase_q == PhaseMax) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + PhaseW'(1);
      end

      if (phase_q == SampleAt) begin
`ifdef RX_BIT_UNSTUFF_EN
        if (ones_cnt_q == OnesMax) begin
          ones_cnt_d = '0;
          if (d_orig) begin
            err_d = 1'b1;
          end else begin
            skip_d = 1'b1;
          end
        end else begin
          shift_d    = 1'b1;
          ones_cnt_d = d_orig ? ones_cnt_q + OnesW'(1) : '0;
        end
`else
        shift_d = 1'b1;
`endif
        if (shift_d) begin
          byte_d    = (bit_cnt_q == BitMax);
          bit_cnt_d = byte_d ? '0 : bit_cnt_q + BitW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= 1'b0;
      byte_q    <= 1'b0;
      skip_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef RX_BIT_UNSTUFF_EN
      ones_cnt_q <= '0;
`endif
    end else begin
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      skip_q    <= skip_d;
      err_q     <= err_d;
`ifdef RX_BIT_UNSTUFF_EN
      ones_cnt_q <= ones_cnt_d;
`endif
    end
  end

  assign shift_enable  = shift_q;
  assign byte_received = byte_q;
  assign stuff_skip    = skip_q;
  assign bit_stuff_err = err_q;

endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// Directed bench for usb_rx_bit_timer: a bit-level model pushes the expected output vector
// {shift_enable, byte_received, stuff_skip, bit_stuff_err} per driven cycle; it is popped after the edge.
module tb_usb_rx_bit_timer;

  localparam int unsigned Cpb = 8;
  localparam int unsigned Sp  = 3;
  localparam int unsigned Bpb = 8;
  localparam int unsigned Sl  = 6;
`ifdef RX_BIT_UNSTUFF_EN
  localparam bit Unstuff = 1'b1;
`else
  localparam bit Unstuff = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic enable_timer = 1'b0;
  logic d_edge = 1'b0;
  logic d_orig = 1'b0;
  logic shift_enable, byte_received, stuff_skip, bit_stuff_err;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];
  int m_age = 0;   // cycles since last resync point, modulo bit period
  int m_bits = 0;  // data bits shifted in current byte
  int m_ones = 0;  // run of sampled ones

  usb_rx_bit_timer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (enable_timer),
    .d_edge       (d_edge),
    .d_orig       (d_orig),
    .shift_enable (shift_enable),
    .byte_received(byte_received),
    .stuff_skip   (stuff_skip),
    .bit_stuff_err(bit_stuff_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic model_push(input logic en, input logic e, input logic d);
    logic [3:0] x;
    x = 4'b0000;
    if (!en) begin
      m_age  = 0;
      m_bits = 0;
      m_ones = 0;
    end else begin
      if (m_age == Sp) begin
        if (Unstuff && m_ones == Sl) begin
          m_ones = 0;
          x = d ? 4'b0001 : 4'b0010;
        end else begin
          m_ones = d ? m_ones + 1 : 0;
          m_bits++;
          if (m_bits == Bpb) begin
            x = 4'b1100;
            m_bits = 0;
          end else begin
            x = 4'b1000;
          end
        end
      end
      m_age = e ? 1 : (m_age + 1) % Cpb;
    end
    exp_q.push_back(x);
  endtask

  task automatic step(input logic en, input logic e, input logic d, input string tag);
    enable_timer = en;
    d_edge = e;
    d_orig = d;
    model_push(en, e, d);
    @(posedge clk);
    #1;
    check(tag, {shift_enable, byte_received, stuff_skip, bit_stuff_err}, exp_q.pop_front());
  endtask

  task automatic bit_period(input logic d, input string tag);
    for (int i = 0; i < Cpb; i++) step(1'b1, 1'b0, d, tag);
  endtask

  initial begin
    // Reset state
    #1 n_rst = 1'b0;
    #1 check("reset_state", {shift_enable, byte_received, stuff_skip, bit_stuff_err}, 4'b0000);
    step(1'b0, 1'b0, 1'b0, "in_reset");
    n_rst = 1'b1;

    // Free-run: strobes at cycles 4,12,...,60, byte at 60
    step(1'b0, 1'b0, 1'b0, "idle");
    for (int k = 0; k < 64; k++) step(1'b1, 1'b0, 1'b0, "freerun");

    // Reset mid-byte: fifth strobe is high, then async reset must clear it at once
    step(1'b0, 1'b0, 1'b0, "idle");
    for (int k = 0; k < 36; k++) step(1'b1, 1'b0, 1'b0, "pre_reset");
    check("fifth_strobe_before_reset", {shift_enable, byte_received}, 4'b0010);
    #1 n_rst = 1'b0;
    #1 check("async_reset_mid_byte", {shift_enable, byte_received, stuff_skip, bit_stuff_err},
             4'b0000);
    step(1'b0, 1'b0, 1'b0, "in_reset");
    n_rst = 1'b1;
    for (int k = 0; k < 64; k++) step(1'b1, 1'b0, 1'b0, "post_reset");

    // Resync at cycle 10 (phase 2), then an edge on a sample cycle (21, phase 3)
    step(1'b0, 1'b0, 1'b0, "idle");
    for (int k = 0; k < 40; k++) step(1'b1, (k == 10 || k == 21), k[0], "resync");

    // Stuffing: 1,1,1,1,1,1,0 then two 0s
    step(1'b0, 1'b0, 1'b0, "idle");
    for (int b = 0; b < 6; b++) bit_period(1'b1, "stuff_ones");
    bit_period(1'b0, "stuff_zero");
    bit_period(1'b0, "stuff_after1");
    bit_period(1'b0, "stuff_after2");

    // Error: seven 1s, then a further 1 and a 0
    step(1'b0, 1'b0, 1'b0, "idle");
    for (int b = 0; b < 7; b++) bit_period(1'b1, "err_ones");
    bit_period(1'b1, "err_next_one");
    bit_period(1'b0, "err_zero");

    // Ones run carried across a byte boundary
    step(1'b0, 1'b0, 1'b0, "idle");
    for (int b = 0; b < 4; b++) bit_period(1'b0, "cross_zero");
    for (int b = 0; b < 8; b++) bit_period(1'b1, "cross_ones");

    // Abort at phase 3 of bit 4, then re-enable
    step(1'b0, 1'b0, 1'b0, "idle");
    for (int k = 0; k < 35; k++) step(1'b1, 1'b0, 1'b1, "pre_abort");
    step(1'b0, 1'b0, 1'b1, "abort");
    for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 1'b0, "reenable");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
